// File: rtl/bin_dense_mul_arbiter_if.sv
// Bundle of requester, shared-multiplier and response signals for bin_dense_mul_arbiter.
// slave is the arbiter's view; master is the view of its environment.
interface bin_dense_mul_arbiter_if #(
  parameter int DIN0_WIDTH = 20,
  parameter int DIN1_WIDTH = 16,
  parameter int DOUT_WIDTH = 36,
  parameter int TAG_WIDTH  = 4
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DIN0_WIDTH-1:0] req0_a;
  logic [DIN1_WIDTH-1:0] req0_b;
  logic [TAG_WIDTH-1:0]  req0_tag;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [DIN0_WIDTH-1:0] req1_a;
  logic [DIN1_WIDTH-1:0] req1_b;
  logic [TAG_WIDTH-1:0]  req1_tag;

  logic [DIN0_WIDTH-1:0] mul_din0;
  logic [DIN1_WIDTH-1:0] mul_din1;
  logic [DOUT_WIDTH-1:0] mul_dout;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DOUT_WIDTH-1:0] rsp_p;
  logic                  rsp_src;
  logic [TAG_WIDTH-1:0]  rsp_tag;

  logic                  idle;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_a, req1_b, req1_tag,
    input  mul_dout, rsp_ready,
    output req0_ready, req1_ready,
    output mul_din0, mul_din1,
    output rsp_valid, rsp_p, rsp_src, rsp_tag, idle
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_tag,
    output req1_valid, req1_a, req1_b, req1_tag,
    output mul_dout, rsp_ready,
    input  req0_ready, req1_ready,
    input  mul_din0, mul_din1,
    input  rsp_valid, rsp_p, rsp_src, rsp_tag, idle
  );
endinterface

// File: rtl/bin_dense_mul_arbiter.sv
// Two-requester round-robin front end for a shared combinational signed multiplier,
// with an operand stage (S1) feeding the multiplier and a result stage (S2).
module bin_dense_mul_arbiter #(
  parameter int DIN0_WIDTH = 20,
  parameter int DIN1_WIDTH = 16,
  parameter int DOUT_WIDTH = 36,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  bin_dense_mul_arbiter_if.slave  bus
);

  logic                  v1_q, v1_d;
  logic [DIN0_WIDTH-1:0] a1_q, a1_d;
  logic [DIN1_WIDTH-1:0] b1_q, b1_d;
  logic                  src1_q, src1_d;
  logic [TAG_WIDTH-1:0]  tag1_q, tag1_d;

  logic                  v2_q, v2_d;
  logic [DOUT_WIDTH-1:0] p2_q, p2_d;
  logic                  src2_q, src2_d;
  logic [TAG_WIDTH-1:0]  tag2_q, tag2_d;

  logic                  last_grant_q, last_grant_d;

  logic adv1, adv2;
  logic gnt0, gnt1;
  logic xfer;

  always_comb begin
    adv2 = !v2_q || bus.rsp_ready;
    adv1 = !v1_q || adv2;
  end

  // Grant depends only on the valids and last_grant; adv1 gates it into ready.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      if (last_grant_q) gnt0 = 1'b1;
      else              gnt1 = 1'b1;
    end else if (bus.req0_valid) begin
      gnt0 = 1'b1;
    end else if (bus.req1_valid) begin
      gnt1 = 1'b1;
    end
  end

  always_comb begin
    bus.req0_ready = gnt0 && adv1 && !ap_rst;
    bus.req1_ready = gnt1 && adv1 && !ap_rst;
    xfer           = bus.req0_ready || bus.req1_ready;
  end

  always_comb begin
    v1_d         = v1_q;
    a1_d         = a1_q;
    b1_d         = b1_q;
    src1_d       = src1_q;
    tag1_d       = tag1_q;
    last_grant_d = last_grant_q;
    if (adv1) begin
      v1_d = xfer;
      if (xfer) begin
        a1_d         = gnt1 ? bus.req1_a   : bus.req0_a;
        b1_d         = gnt1 ? bus.req1_b   : bus.req0_b;
        tag1_d       = gnt1 ? bus.req1_tag : bus.req0_tag;
        src1_d       = gnt1;
        last_grant_d = gnt1;
      end
    end
  end

  always_comb begin
    v2_d   = v2_q;
    p2_d   = p2_q;
    src2_d = src2_q;
    tag2_d = tag2_q;
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        p2_d   = bus.mul_dout;
        src2_d = src1_q;
        tag2_d = tag1_q;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      v1_q         <= 1'b0;
      a1_q         <= '0;
      b1_q         <= '0;
      src1_q       <= 1'b0;
      tag1_q       <= '0;
      v2_q         <= 1'b0;
      p2_q         <= '0;
      src2_q       <= 1'b0;
      tag2_q       <= '0;
      last_grant_q <= 1'b1;
    end else begin
      v1_q         <= v1_d;
      a1_q         <= a1_d;
      b1_q         <= b1_d;
      src1_q       <= src1_d;
      tag1_q       <= tag1_d;
      v2_q         <= v2_d;
      p2_q         <= p2_d;
      src2_q       <= src2_d;
      tag2_q       <= tag2_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    bus.mul_din0  = a1_q;
    bus.mul_din1  = b1_q;
    bus.rsp_valid = v2_q;
    bus.rsp_p     = p2_q;
    bus.rsp_src   = src2_q;
    bus.rsp_tag   = tag2_q;
    bus.idle      = !v1_q && !v2_q;
  end

endmodule

// File: tb/tb_bin_dense_mul_arbiter.sv
// Directed bench for bin_dense_mul_arbiter with a behavioural signed multiplier.
module tb_bin_dense_mul_arbiter;
  localparam int DW0 = 20;
  localparam int DW1 = 16;
  localparam int DWO = 36;
  localparam int TW  = 4;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  bin_dense_mul_arbiter_if #(.DIN0_WIDTH(DW0), .DIN1_WIDTH(DW1),
                             .DOUT_WIDTH(DWO), .TAG_WIDTH(TW)) bus ();

  assign bus.mul_dout = $signed(bus.mul_din0) * $signed(bus.mul_din1);

  bin_dense_mul_arbiter #(.DIN0_WIDTH(DW0), .DIN1_WIDTH(DW1),
                          .DOUT_WIDTH(DWO), .TAG_WIDTH(TW)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_tag = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_tag = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.rsp_ready = 1'b1;
    ap_rst = 1'b1;
    tick();
    tick();
    ap_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.rsp_ready  = 1'b1;
    ap_rst         = 1'b1;
    bus.req0_valid = 1'b1;
    tick();
    total++;
    if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
    total++;
    if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b want=0", bus.req0_ready); end
    total++;
    if (bus.idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", bus.idle); end
    total++;
    if (bus.mul_din0 !== 20'd0 || bus.mul_din1 !== 16'd0) begin
      bad++; $display("FAIL reset_mul_din got=%h/%h want=0/0", bus.mul_din0, bus.mul_din1);
    end
    do_reset();
  endtask

  task automatic test_single();
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 20'sd3; bus.req0_b = -16'sd5; bus.req0_tag = 4'd7;
    #1;
    total++;
    if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", bus.req0_ready); end
    tick();
    idle_inputs();
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.idle !== 1'b0) begin
      bad++; $display("FAIL single_s1 rsp_valid=%b idle=%b want 0/0", bus.rsp_valid, bus.idle);
    end
    tick();
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== -36'sd15 || bus.rsp_src !== 1'b0 || bus.rsp_tag !== 4'd7) begin
      bad++; $display("FAIL single_rsp got v=%b p=%0d src=%b tag=%0d want v=1 p=-15 src=0 tag=7",
                      bus.rsp_valid, $signed(bus.rsp_p), bus.rsp_src, bus.rsp_tag);
    end
    tick();
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.idle !== 1'b1) begin
      bad++; $display("FAIL single_drain rsp_valid=%b idle=%b want 0/1", bus.rsp_valid, bus.idle);
    end
  endtask

  task automatic test_contention();
    logic signed [DWO-1:0] exp_p;
    do_reset();
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 20'sd10;  bus.req0_b = 16'sd2; bus.req0_tag = 4'd1;
    bus.req1_valid = 1'b1; bus.req1_a = -20'sd7;  bus.req1_b = 16'sd3; bus.req1_tag = 4'd2;
    for (int i = 1; i <= 6; i++) begin
      #1;
      total++;
      if (bus.req0_ready !== ((i - 1) % 2 == 0) || bus.req1_ready !== ((i - 1) % 2 == 1)) begin
        bad++; $display("FAIL contention_grant edge=%0d got r0=%b r1=%b", i, bus.req0_ready, bus.req1_ready);
      end
      tick();
      if (i >= 2) begin
        exp_p = ((i - 2) % 2 == 0) ? 36'sd20 : -36'sd21;
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_src !== ((i - 2) % 2 == 1) || bus.rsp_p !== exp_p ||
            bus.rsp_tag !== (((i - 2) % 2 == 0) ? 4'd1 : 4'd2)) begin
          bad++; $display("FAIL contention_rsp edge=%0d got v=%b src=%b p=%0d tag=%0d want p=%0d",
                          i, bus.rsp_valid, bus.rsp_src, $signed(bus.rsp_p), bus.rsp_tag, exp_p);
        end
      end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_back_pressure();
    do_reset();
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 20'sd1; bus.req0_b = 16'sd4; bus.req0_tag = 4'd1;
    tick();
    bus.req0_a = 20'sd2; bus.req0_tag = 4'd2;
    tick();
    bus.req0_a = 20'sd3; bus.req0_tag = 4'd3;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 36'sd4 || bus.rsp_tag !== 4'd1 || bus.req0_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%b p=%0d tag=%0d ready=%b want 1/4/1/0",
                        i, bus.rsp_valid, $signed(bus.rsp_p), bus.rsp_tag, bus.req0_ready);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    total++;
    if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", bus.req0_ready); end
    tick();
    idle_inputs();
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 36'sd8 || bus.rsp_tag !== 4'd2) begin
      bad++; $display("FAIL bp_second got v=%b p=%0d tag=%0d want 1/8/2", bus.rsp_valid, $signed(bus.rsp_p), bus.rsp_tag);
    end
    tick();
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 36'sd12 || bus.rsp_tag !== 4'd3) begin
      bad++; $display("FAIL bp_third got v=%b p=%0d tag=%0d want 1/12/3", bus.rsp_valid, $signed(bus.rsp_p), bus.rsp_tag);
    end
    tick();
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.idle !== 1'b1) begin
      bad++; $display("FAIL bp_drain got v=%b idle=%b want 0/1", bus.rsp_valid, bus.idle);
    end
  endtask

  task automatic test_extremes();
    do_reset();
    bus.rsp_ready  = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_a = -20'sd524288; bus.req1_b = -16'sd32768; bus.req1_tag = 4'd5;
    tick();
    bus.req1_a = 20'sd524287; bus.req1_tag = 4'd6;
    tick();
    idle_inputs();
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 36'sd17179869184 || bus.rsp_src !== 1'b1 || bus.rsp_tag !== 4'd5) begin
      bad++; $display("FAIL extreme_negneg got v=%b p=%0d src=%b tag=%0d want p=17179869184 src=1 tag=5",
                      bus.rsp_valid, $signed(bus.rsp_p), bus.rsp_src, bus.rsp_tag);
    end
    tick();
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== -36'sd17179836416 || bus.rsp_tag !== 4'd6) begin
      bad++; $display("FAIL extreme_posneg got v=%b p=%0d tag=%0d want p=-17179836416 tag=6",
                      bus.rsp_valid, $signed(bus.rsp_p), bus.rsp_tag);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 20'sd9; bus.req0_b = 16'sd9; bus.req0_tag = 4'd9;
    tick();
    tick();
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.idle !== 1'b0) begin
      bad++; $display("FAIL midrst_setup got v=%b idle=%b want 1/0", bus.rsp_valid, bus.idle);
    end
    #2;
    ap_rst = 1'b1;
    #1;
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.idle !== 1'b1) begin
      bad++; $display("FAIL midrst_async got v=%b idle=%b want 0/1", bus.rsp_valid, bus.idle);
    end
    idle_inputs();
    bus.rsp_ready = 1'b1;
    tick();
    ap_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale cyc=%0d got v=%b want 0", i, bus.rsp_valid); end
    end
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    total++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_grant got r0=%b r1=%b want 1/0", bus.req0_ready, bus.req1_ready);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    bus.rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_extremes();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end
endmodule

// File: doc/bin_dense_mul_arbiter.md
BIN_DENSE_MUL_ARBITER -- requirements
Module: bin_dense_mul_arbiter

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 20: width of operand A (signed).
REQ-002 SHALL have parameter DIN1_WIDTH, default 16: width of operand B (signed).
REQ-003 SHALL have parameter DOUT_WIDTH, default 36: product width, equal to DIN0_WIDTH+DIN1_WIDTH.
REQ-004 SHALL have parameter TAG_WIDTH, default 4: requester-supplied tag width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: ap_clk  in  1  clock, rising edge.
REQ-006 ap_rst  in  1  asynchronous active-high reset.
REQ-007 reqN_valid  in  1  requester N (N=0,1) operand valid.
REQ-008 reqN_ready  out  1  requester N operands accepted this cycle.
REQ-009 reqN_a  in  DIN0_WIDTH  signed operand A.
REQ-010 reqN_b  in  DIN1_WIDTH  signed operand B.
REQ-011 reqN_tag  in  TAG_WIDTH  opaque tag, returned with the result.
REQ-012 mul_din0  out  DIN0_WIDTH  operand A to the shared combinational signed multiplier.
REQ-013 mul_din1  out  DIN1_WIDTH  operand B to the shared multiplier.
REQ-014 mul_dout  in  DOUT_WIDTH  product from the shared multiplier (combinational, same cycle).
REQ-015 rsp_valid  out  1  result valid.
REQ-016 rsp_ready  in  1  consumer accepts the result.
REQ-017 rsp_p  out  DOUT_WIDTH  signed product.
REQ-018 rsp_src  out  1  index of the requester that issued the operands.
REQ-019 rsp_tag  out  TAG_WIDTH  tag of the issuing request.
REQ-020 idle  out  1  high when both pipeline stages are empty.

Function
REQ-021 SHALL implement a 2-stage pipeline: S1 (operand reg: a, b, src, tag, v1) and S2 (result reg: p, src, tag, v2).
REQ-022 mul_din0/mul_din1 SHALL be driven from the S1 registers only, never from the request ports.
REQ-023 Pipeline advance: adv2 = !v2 | rsp_ready; adv1 = !v1 | adv2.
REQ-024 Handshake: a request transfers on the rising edge at which reqN_valid & reqN_ready are both high; reqN_ready = grantN & adv1.
REQ-025 Arbitration: round-robin over 2 requesters using register last_grant; when both are valid, grant the requester != last_grant; when one is valid, grant it; when none, no grant.
REQ-026 last_grant SHALL update only on a completed transfer; at most one grant per cycle.
REQ-027 reqN_ready MAY be high while reqN_valid is low; grant is combinational from the valids and last_grant.
REQ-028 On adv1, S1 loads the granted request (v1=1), or v1=0 when there is no transfer.
REQ-029 On adv2, S2 loads p=mul_dout and src/tag from S1, and v2=v1.
REQ-030 Latency: a transfer at edge k gives rsp_valid=1 after edge k+1 (two edges, transfer to S1 then S2) with rsp_ready held high.
REQ-031 Throughput: one result per cycle when rsp_ready stays high; no bubble between back-to-back requests.
REQ-032 Back-pressure: while rsp_valid & !rsp_ready, S2 holds rsp_p/rsp_src/rsp_tag stable; S1 holds if v1; reqN_ready=0 if v1.
REQ-033 Results SHALL be returned in acceptance order; no drop, no duplication.
REQ-034 rsp_p SHALL equal the signed product of the accepted a and b, full DOUT_WIDTH, no truncation (e.g. -524288 * -32768 = 17179869184).
REQ-035 idle = !v1 & !v2.

Reset
REQ-036 While ap_rst=1: v1=v2=0, rsp_valid=0, reqN_ready=0, idle=1, last_grant=1 (so requester 0 wins the first contention), data regs = 0, mul_din0/mul_din1 = 0.
REQ-037 Reset asserted mid-operation SHALL discard in-flight S1/S2 contents immediately (asynchronous); no result is emitted for them after release.
REQ-038 First transfer SHALL be possible on the first rising edge after ap_rst deasserts.

Verification
REQ-039 Single request: req0 a=3, b=-5, tag=7, rsp_ready=1 -> rsp_valid after 2 edges, rsp_p=-15, rsp_src=0, rsp_tag=7, idle returns to 1.
REQ-040 Contention: both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1...; rsp_src sequence 0,1,0,1 with correct products, one per cycle.
REQ-041 Back-pressure: 3 req0 transfers, rsp_ready=0 for 5 cycles -> first result held stable, reqN_ready=0 once S1 is full, no loss; releasing rsp_ready yields all 3 in order.
REQ-042 Extremes: a=-524288, b=-32768 -> rsp_p=17179869184; a=524287, b=-32768 -> rsp_p=-17179836416.
REQ-043 Reset mid-flight: ap_rst pulsed with v1=v2=1 -> rsp_valid=0 immediately, no stale response after release, next contention grants requester 0.
